// File: rtl/ece571f23_g5_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ece571f23_g5_aes_round_ctrl
// Description : Iterative AES-128 encryption round sequencer.
//               Takes a plaintext/cipher-key pair over a valid/ready handshake
//               and performs the initial AddRoundKey (text ^ key). It then
//               steps an external one-round datapath and a one-step
//               key-expansion block through NR rounds. It supplies rcon and
//               the last-round MixColumns bypass, and returns the ciphertext
//               over a second valid/ready handshake.
//
// Ports       : clk            in   single clock, rising edge
//               rst            in   asynchronous, active-high reset
//               in_valid       in   plaintext/key pair presented
//               in_ready       out  controller can accept a pair
//               plaintext      in   input block
//               cipher_key     in   cipher key (round key 0)
//               out_valid      out  ciphertext valid
//               out_ready      in   consumer accepts ciphertext
//               ciphertext     out  result block, 0 when out_valid=0
//               dp_state       out  registered state to round datapath
//               dp_prev_key    out  registered round key r-1 to key step
//               dp_rcon        out  rcon for current round r (0 outside ROUND)
//               dp_last_round  out  high in final round, bypass MixColumns
//               dp_next_state  in   combinational round result for round r
//               dp_next_key    in   combinational round key r
//               busy           out  high in any state other than IDLE
//               round          out  current round counter, 0 in IDLE/DONE
//
// Revision    : 1.0  initial release
// ============================================================================
module ece571f23_g5_aes_round_ctrl #(
    parameter int DATA_W = 128,
    parameter int NR     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] plaintext,
    input  logic [DATA_W-1:0] cipher_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ciphertext,
    output logic [DATA_W-1:0] dp_state,
    output logic [DATA_W-1:0] dp_prev_key,
    output logic [7:0]        dp_rcon,
    output logic              dp_last_round,
    input  logic [DATA_W-1:0] dp_next_state,
    input  logic [DATA_W-1:0] dp_next_key,
    output logic              busy,
    output logic [3:0]        round
);

    // ------------------------------------------------------------------------
    // State encoding. Encoding 2'd3 is unreachable and falls back to IDLE.
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_round = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [3:0] c_nr = 4'(NR);

    // Round constants for AES-128 rounds 1..10; anything else yields 0.
    function automatic logic [7:0] rcon_lut(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [3:0]        r_round;
    logic [DATA_W-1:0] r_text;
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] r_ct;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic [7:0]        r_rcon;
    logic              r_last;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]        w_state_nxt;
    logic [3:0]        w_round_nxt;
    logic [DATA_W-1:0] w_text_nxt;
    logic [DATA_W-1:0] w_key_nxt;
    logic [DATA_W-1:0] w_ct_nxt;
    logic              w_accept;
    logic              w_deliver;

    // Handshakes qualify on the registered ready/valid so that they are
    // exactly what the outside world sees this cycle.
    assign w_accept  = (r_state == c_st_idle) && in_valid && r_in_ready;
    assign w_deliver = (r_state == c_st_done) && r_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_text_nxt  = r_text;
        w_key_nxt   = r_key;
        w_ct_nxt    = r_ct;

        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    // Initial AddRoundKey happens here; the datapath only
                    // ever sees rounds 1..NR.
                    w_text_nxt  = plaintext ^ cipher_key;
                    w_key_nxt   = cipher_key;
                    w_round_nxt = 4'd1;
                    w_state_nxt = c_st_round;
                end
            end

            c_st_round: begin
                w_text_nxt = dp_next_state;
                w_key_nxt  = dp_next_key;
                if (r_round == c_nr) begin
                    // The final round's result is captured directly into the
                    // output register so ciphertext is registered in DONE.
                    w_ct_nxt    = dp_next_state;
                    w_round_nxt = 4'd0;
                    w_state_nxt = c_st_done;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end

            c_st_done: begin
                if (w_deliver) begin
                    // Clearing here keeps ciphertext at 0 whenever out_valid=0.
                    w_ct_nxt    = '0;
                    w_state_nxt = c_st_idle;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
                w_round_nxt = 4'd0;
                w_ct_nxt    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers. All handshake and datapath-control outputs
    // are decoded from the next state and registered, so they are glitch-free
    // and line up with the state they describe.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_round     <= 4'd0;
            r_text      <= '0;
            r_key       <= '0;
            r_ct        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rcon      <= 8'h00;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_round     <= w_round_nxt;
            r_text      <= w_text_nxt;
            r_key       <= w_key_nxt;
            r_ct        <= w_ct_nxt;
            r_in_ready  <= (w_state_nxt == c_st_idle);
            r_out_valid <= (w_state_nxt == c_st_done);
            r_busy      <= (w_state_nxt != c_st_idle);
            r_rcon      <= (w_state_nxt == c_st_round) ? rcon_lut(w_round_nxt) : 8'h00;
            r_last      <= (w_state_nxt == c_st_round) && (w_round_nxt == c_nr);
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign ciphertext    = r_ct;
    assign dp_state      = r_text;
    assign dp_prev_key   = r_key;
    assign dp_rcon       = r_rcon;
    assign dp_last_round = r_last;
    assign busy          = r_busy;
    assign round         = r_round;

endmodule
`default_nettype wire

// File: tb/tb_ece571f23_g5_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ece571f23_g5_aes_round_ctrl
// Description : Self-checking bench for the AES-128 round sequencer. A
//               behavioural one-round AES datapath and key-expansion step
//               close the loop around the controller. Expected ciphertexts
//               are the published FIPS-197 vectors; a scoreboard queue is
//               filled on accept and drained by an output monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ece571f23_g5_aes_round_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] cipher_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic [127:0] dp_state;
    logic [127:0] dp_prev_key;
    logic [7:0]   dp_rcon;
    logic         dp_last_round;
    logic [127:0] dp_next_state;
    logic [127:0] dp_next_key;
    logic         busy;
    logic [3:0]   round;

    ece571f23_g5_aes_round_ctrl #(.DATA_W(128), .NR(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .plaintext     (plaintext),
        .cipher_key    (cipher_key),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ciphertext    (ciphertext),
        .dp_state      (dp_state),
        .dp_prev_key   (dp_prev_key),
        .dp_rcon       (dp_rcon),
        .dp_last_round (dp_last_round),
        .dp_next_state (dp_next_state),
        .dp_next_key   (dp_next_key),
        .busy          (busy),
        .round         (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural AES round datapath
    // ------------------------------------------------------------------------
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [79:0] RCON_EXP = 80'h01020408102040801b36;

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb(s[127 - 8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c + r] = a[4*((c + r) % 4) + r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
                b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
                b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
                b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    assign dp_next_key   = key_step(dp_prev_key, dp_rcon);
    assign dp_next_state = round_fn(dp_state, dp_next_key, dp_last_round);

    // ------------------------------------------------------------------------
    // Test vectors
    // ------------------------------------------------------------------------
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int           errors = 0;
    int           checks = 0;
    int           cycle  = 0;
    int           n_delivered = 0;
    int           del_last = 0;
    int           del_prev = 0;
    logic [127:0] sb_q [$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: a handshake seen at the falling edge completes on the
    // next rising edge, which is recorded as the delivery cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no output", ciphertext);
                end else begin
                    chk("ciphertext", ciphertext, sb_q.pop_front());
                end
                del_prev = del_last;
                del_last = cycle + 1;
                n_delivered++;
            end else if (!out_valid) begin
                chk("ct_zero_when_invalid", ciphertext, 128'h0);
            end
        end
    end

    // Present a pair and hold it until accepted; acc is the accept edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] exp, output int acc);
        plaintext  = pt;
        cipher_key = key;
        in_valid   = 1'b1;
        acc        = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cycle + 1;
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 60 cycles");
            in_valid = 1'b0;
        end else begin
            sb_q.push_back(exp);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_delivered(input int target);
        for (int i = 0; i < 80 && n_delivered < target; i++) @(posedge clk);
        #1;
        chk("delivery_count", 128'(n_delivered), 128'(target));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int acc1, acc2, target;
        logic [79:0] rc_tbl;
        rc_tbl     = RCON_EXP;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        plaintext  = '0;
        cipher_key = '0;

        // Reset values
        step(3);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_ct",        ciphertext,      128'h0);
        chk("rst_round",     128'(round),     128'd0);
        chk("rst_rcon",      128'(dp_rcon),   128'd0);
        @(negedge clk);
        rst = 1'b0;
        step(2);

        // 1: FIPS-197 App.B with latency check
        out_ready = 1'b1;
        target = n_delivered + 1;
        send(PT_B, KEY_B, CT_B, acc1);
        wait_delivered(target);
        chk("latency_accept_to_deliver", 128'(del_last - acc1), 128'd11);
        step(2);

        // 2: FIPS-197 C.1 with rcon / last-round sequence
        target = n_delivered + 1;
        send(PT_C, KEY_C, CT_C, acc1);
        chk("busy_in_round", 128'(busy), 128'd1);
        chk("in_ready_in_round", 128'(in_ready), 128'd0);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("round_%0d", k), 128'(round), 128'(k));
            chk($sformatf("rcon_%0d", k), 128'(dp_rcon), 128'(rc_tbl[8*(10-k) +: 8]));
            chk($sformatf("last_round_%0d", k), 128'(dp_last_round), 128'(k == 10));
            step(1);
        end
        chk("rcon_after_rounds", 128'(dp_rcon), 128'd0);
        wait_delivered(target);
        step(2);

        // 3: backpressure in DONE
        out_ready = 1'b0;
        target = n_delivered + 1;
        send(PT_B, KEY_B, CT_B, acc1);
        for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_ct_stable", ciphertext, CT_B);
            chk("bp_in_ready",  128'(in_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        step(1);
        chk("bp_release_in_ready",  128'(in_ready),  128'd1);
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);
        chk("bp_release_busy",      128'(busy),      128'd0);
        chk("bp_delivered", 128'(n_delivered), 128'(target));
        step(2);

        // 4: in_valid toggling with foreign data during ROUND is ignored
        target = n_delivered + 1;
        send(PT_C, KEY_C, CT_C, acc1);
        for (int i = 0; i < 6; i++) begin
            in_valid   = ~in_valid;
            plaintext  = {4{$urandom}};
            cipher_key = {4{$urandom}};
            step(1);
        end
        in_valid = 1'b0;
        wait_delivered(target);
        step(15);
        chk("no_extra_output", 128'(n_delivered), 128'(target));

        // 5: asynchronous reset at round 5
        send(PT_B, KEY_B, CT_B, acc1);
        step(4);
        chk("pre_reset_round", 128'(round), 128'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",      128'(busy),      128'd0);
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_round",     128'(round),     128'd0);
        chk("arst_in_ready",  128'(in_ready),  128'd1);
        chk("arst_rcon",      128'(dp_rcon),   128'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1);
        target = n_delivered + 1;
        send(PT_C, KEY_C, CT_C, acc1);
        wait_delivered(target);
        step(2);

        // 6: back-to-back blocks with out_ready held high
        target = n_delivered + 2;
        send(PT_B, KEY_B, CT_B, acc1);
        send(PT_C, KEY_C, CT_C, acc2);
        wait_delivered(target);
        chk("b2b_accept_spacing",    128'(acc2 - acc1),     128'd12);
        chk("b2b_deliver_spacing",   128'(del_last - del_prev), 128'd12);
        chk("b2b_accept_after_dlv",  128'(acc2 - del_prev), 128'd1);

        step(4);
        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
